// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, defaults and width helper for the stash playback reader
package stopwatch_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SHOW   = 3'd2,
        STEP   = 3'd3,
        REWIND = 3'd4
    } state_t;

    localparam int DATA_W_DEF = 8;

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stash_player_hold_timer.sv
// hold_timer: counts display ticks since the last clear and flags the final one
module hold_timer #(
    parameter int HOLD_TICKS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic done
);

    logic [7:0] cnt;

    // tick counter, parked at the target so a late tick cannot wrap it
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (tick && cnt != 8'(HOLD_TICKS))
            cnt <= cnt + 8'd1;
    end

    assign done = tick && (cnt == 8'(HOLD_TICKS - 1));

endmodule

// File: rtl/stash_player.sv
// stash_player: steps through the stored Stash entries on request and rewinds Stash to entry 0
module stash_player
    import stopwatch_pkg::*;
#(
    parameter int DEPTH      = 5,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int HOLD_TICKS = 3,
    localparam int IW        = idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              sample_in_valid,
    input  logic              play,
    input  logic [DATA_W-1:0] sample_out,
    output logic              next_sample,
    output logic [DATA_W-1:0] shown_sample,
    output logic [IW-1:0]     shown_index,
    output logic              playing,
    output logic              empty
);

    localparam int CW = $clog2(DEPTH + 1);

    state_t        state, state_n;
    logic [CW-1:0] count, limit;
    logic [IW-1:0] ptr, ptr_n;
    logic          ns_d, hold_done;

    hold_timer #(.HOLD_TICKS(HOLD_TICKS)) u_hold (
        .clk   (clk),
        .reset (reset),
        .clear (state == LOAD),
        .tick  (tick && state == SHOW),
        .done  (hold_done)
    );

    // ptr_n is the Stash read pointer as it will stand after this edge
    assign ptr_n   = next_sample ? ((ptr == IW'(DEPTH - 1)) ? '0 : ptr + IW'(1)) : ptr;
    assign playing = state != IDLE;
    assign empty   = count == '0;

    // next state, and the advance strobe decoded from it so it can be registered
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = (play && count != '0) ? LOAD : IDLE;
            LOAD:    state_n = SHOW;
            SHOW:    state_n = play ? REWIND :
                               !hold_done ? SHOW :
                               ((CW'(ptr) + CW'(1)) < limit) ? STEP : REWIND;
            STEP:    state_n = LOAD;
            REWIND:  state_n = (ptr_n == '0) ? IDLE : REWIND;
            default: state_n = IDLE;
        endcase
        ns_d = (state_n == STEP) || (state_n == REWIND && ptr_n != '0);
    end

    // state, strobe and pointer mirror
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            next_sample <= 1'b0;
            ptr         <= '0;
        end else begin
            state       <= state_n;
            next_sample <= ns_d;
            ptr         <= ptr_n;
        end
    end

    // saturating entry count, and the playback length frozen at start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            limit <= '0;
        end else begin
            if (sample_in_valid && count != CW'(DEPTH))
                count <= count + CW'(1);
            if (state == IDLE && state_n == LOAD)
                limit <= count;
        end
    end

    // display registers, captured once per entry and held while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shown_sample <= '0;
            shown_index  <= '0;
        end else if (state == LOAD) begin
            shown_sample <= sample_out;
            shown_index  <= ptr;
        end
    end

endmodule

// File: tb/tb_stash_player.sv
// tb_stash_player: scoreboard bench for stash_player alongside a behavioural Stash
module tb_stash_player;

    localparam int DEPTH = 5;
    localparam int DW    = 8;
    localparam int HOLD  = 2;

    logic          clk = 0, reset = 1, tick = 0, sample_in_valid = 0, play = 0;
    logic [DW-1:0] sample_in = '0, sample_out;
    logic          next_sample, playing, empty;
    logic [DW-1:0] shown_sample;
    logic [2:0]    shown_index;

    int errors = 0, checks = 0;

    stash_player #(.DEPTH(DEPTH), .DATA_W(DW), .HOLD_TICKS(HOLD)) dut (
        .clk             (clk),
        .reset           (reset),
        .tick            (tick),
        .sample_in_valid (sample_in_valid),
        .play            (play),
        .sample_out      (sample_out),
        .next_sample     (next_sample),
        .shown_sample    (shown_sample),
        .shown_index     (shown_index),
        .playing         (playing),
        .empty           (empty)
    );

    always #5 clk = ~clk;

    // Stash: fills entries once each, read pointer advanced by next_sample
    logic [DW-1:0] mem [DEPTH];
    int wr, rd;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wr <= 0;
            rd <= 0;
        end else begin
            if (sample_in_valid && wr < DEPTH) begin
                mem[wr] <= sample_in;
                wr <= wr + 1;
            end
            if (next_sample) rd <= (rd + 1) % DEPTH;
        end
    end
    assign sample_out = mem[rd];

    initial forever begin
        repeat (3) @(posedge clk);
        #1 tick = 1;
        @(posedge clk);
        #1 tick = 0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int            k;
        logic [DW-1:0] ent [DEPTH];
    } sess_t;

    logic [DW-1:0] stored [$];
    sess_t sq [$];

    task automatic do_reset();
        reset = 1;
        #1;
        chk("rst_next_sample", next_sample, 0);
        chk("rst_shown_sample", shown_sample, 0);
        chk("rst_shown_index", shown_index, 0);
        chk("rst_playing", playing, 0);
        chk("rst_empty", empty, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        stored.delete();
    endtask

    task automatic do_write(input logic [DW-1:0] d);
        sample_in_valid = 1;
        sample_in = d;
        @(negedge clk);
        sample_in_valid = 0;
        if (stored.size() < DEPTH) stored.push_back(d);
        chk("empty_after_write", empty, 0);
    endtask

    task automatic wait_index(input int j);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (shown_index == 3'(j)) return;
        end
        chk("wait_index_timeout", shown_index, j);
    endtask

    task automatic do_play(input int abort_at = -1, input int wval = -1);
        sess_t s;
        int n = stored.size();
        play = 1;
        if (wval >= 0) begin
            sample_in_valid = 1;
            sample_in = DW'(wval);
        end
        if (n > 0) begin
            s.k = (abort_at >= 0 && abort_at < n) ? abort_at + 1 : n;
            for (int i = 0; i < DEPTH; i++) s.ent[i] = (i < n) ? stored[i] : '0;
            sq.push_back(s);
        end
        @(negedge clk);
        play = 0;
        sample_in_valid = 0;
        if (wval >= 0 && stored.size() < DEPTH) stored.push_back(DW'(wval));
        if (n > 0 && abort_at >= 0 && abort_at < n) begin
            wait_index(abort_at);
            play = 1;
            @(negedge clk);
            play = 0;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (!playing) return;
            @(negedge clk);
        end
        chk("idle_timeout", playing, 0);
    endtask

    // monitor: pops one playback per rising playing and checks every displayed entry
    sess_t cur;
    bit in_sess = 0, disp_due = 0, pl1 = 0, ns1 = 0, ns2 = 0;
    int kseen = 0, pulses = 0, tcnt = 0, tpulse = 0;
    always @(negedge clk) begin
        if (reset) begin
            in_sess = 0; disp_due = 0; pl1 = 0; ns1 = 0; ns2 = 0;
        end else begin
            if (disp_due) begin
                disp_due = 0;
                if (kseen < cur.k) begin
                    chk("shown_sample", shown_sample, cur.ent[kseen]);
                    chk("shown_index", shown_index, kseen);
                end else
                    chk("extra_display", kseen, cur.k - 1);
                kseen++;
                tcnt = 0;
            end
            if (!in_sess) chk("stray_pulse", next_sample, 0);
            if (in_sess && next_sample) pulses++;
            if (next_sample && !ns1) tpulse = tcnt;
            if (in_sess && !next_sample && ns1 && !ns2 && playing) begin
                chk("hold_ticks", tpulse, HOLD);
                disp_due = 1;
            end
            if (in_sess && !next_sample) tcnt += int'(tick);
            if (playing && !pl1) begin
                if (sq.size() == 0)
                    chk("unexpected_play", playing, 0);
                else begin
                    cur = sq.pop_front();
                    in_sess = 1; kseen = 0; pulses = 0; tcnt = 0; disp_due = 1;
                end
            end else if (!playing && pl1 && in_sess) begin
                chk("entries_shown", kseen, cur.k);
                chk("pulses", pulses, (cur.k - 1) + (DEPTH - (cur.k - 1)) % DEPTH);
                chk("stash_at_0", rd, 0);
                in_sess = 0;
            end
            pl1 = playing;
            ns2 = ns1;
            ns1 = next_sample;
        end
    end

    initial begin
        @(negedge clk);
        do_reset();
        // nothing stored: play ignored
        do_play();
        repeat (20) @(negedge clk);
        chk("t2_playing", playing, 0);
        chk("t2_empty", empty, 1);
        // three entries
        for (int i = 0; i < 3; i++) do_write(DW'(8'h30 + i));
        do_play();
        wait_idle();
        // full buffer, replayed twice
        do_reset();
        for (int i = 0; i < 5; i++) do_write(DW'(8'h30 + i));
        do_play();
        wait_idle();
        do_play();
        wait_idle();
        // abort at index 1
        do_reset();
        for (int i = 0; i < 3; i++) do_write(DW'(8'h40 + i));
        do_play(1);
        wait_idle();
        chk("t4_stash_ptr", rd, 0);
        // saturation, then a write during playback
        do_reset();
        for (int i = 0; i < 6; i++) do_write(DW'(8'h50 + i));
        chk("t5_stored", stored.size(), DEPTH);
        do_play();
        wait_idle();
        do_reset();
        do_write(8'h61);
        do_write(8'h62);
        do_play();
        do_write(8'h63);
        wait_idle();
        // play coincident with the first write sees an empty buffer
        do_reset();
        do_play(-1, 8'h71);
        repeat (10) @(negedge clk);
        chk("coincident_play", playing, 0);
        do_play();
        wait_idle();
        // reset during SHOW at index 2
        do_reset();
        for (int i = 0; i < 3; i++) do_write(DW'(8'h80 + i));
        do_play();
        wait_index(2);
        do_reset();
        do_play();
        repeat (20) @(negedge clk);
        chk("t6_playing", playing, 0);
        chk("t6_empty", empty, 1);
        do_write(8'h55);
        do_play();
        wait_idle();
        // randomized sessions
        for (int r = 0; r < 8; r++) begin
            int nw = $urandom_range(1, 7);
            int ab;
            do_reset();
            for (int i = 0; i < nw; i++) do_write(DW'($urandom));
            ab = $urandom_range(0, 1) ? $urandom_range(0, stored.size() - 1) : -1;
            do_play(ab);
            wait_idle();
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk("sessions_left", sq.size(), 0);
        chk("session_open", int'(in_sess), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
